av_burst_master: RTL and testbench

- Parametrised Avalon-MM burst master; next generation of the single-channel data-memory bus bridge.
- Core side: decoupled valid/ready command, write-data and read-response streams.
- Avalon side: one master port with configurable data/address width and maximum burst length.
- Read data is buffered in an internal FIFO. A read burst is issued only when the FIFO can absorb every beat, so the core may stall reads without blocking the interconnect.

---
 rtl/av_burst_master.sv | 136 +++++++++++++
 tb/tb_av_burst_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/av_burst_master.sv
// rtl/av_burst_master.sv - Avalon-MM burst master with read-response FIFO
// Optional macro AV_BURST_MASTER_BYTEENABLE_EN routes wr_be to av_byteenable during writes.
module av_burst_master #(
    parameter int  DATA_W        = 32,
    parameter int  ADDR_W        = 32,
    parameter int  MAX_BURST     = 16,
    parameter int  RD_FIFO_DEPTH = 32,
    localparam int BC_W          = $clog2(MAX_BURST) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [BC_W-1:0]     cmd_burstcount,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                err_unexpected,
    output logic [ADDR_W-1:0]   av_address,
    output logic                av_read,
    output logic                av_write,
    input  logic                av_waitrequest,
    input  logic [DATA_W-1:0]   av_readdata,
    input  logic                av_readdatavalid,
    output logic [DATA_W-1:0]   av_writedata,
    output logic [DATA_W/8-1:0] av_byteenable,
    output logic [BC_W-1:0]     av_burstcount,
    output logic                av_beginbursttransfer
);
    localparam int PW = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(RD_FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ_REQ, READ_DATA} state_t;
    state_t state, state_nxt;

    logic [BC_W-1:0]   bc;
    logic [BC_W-1:0]   beat_cnt;
    logic              first;
    logic [DATA_W:0]   fifo_mem [RD_FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_cnt, fifo_free;
    logic              in_read, push, pop, accept, beat_last, wr_xfer;

    always_comb begin
        if (cmd_burstcount == '0)
            bc = BC_W'(1);
        else if (cmd_burstcount > BC_W'(MAX_BURST))
            bc = BC_W'(MAX_BURST);
        else
            bc = cmd_burstcount;
    end

    assign fifo_free = CW'(RD_FIFO_DEPTH) - fifo_cnt;
    assign in_read   = (state == READ_REQ) || (state == READ_DATA);
    assign push      = av_readdatavalid && in_read;
    assign pop       = rd_valid && rd_ready;
    assign beat_last = (beat_cnt == av_burstcount - BC_W'(1));

    // Reads are admitted only when the FIFO can absorb the whole burst.
    assign cmd_ready = !rst && (state == IDLE) && (cmd_write || (fifo_free >= CW'(bc)));
    assign accept    = cmd_valid && cmd_ready;

    assign wr_ready              = (state == WRITE) && !av_waitrequest;
    assign av_write              = (state == WRITE) && wr_valid;
    assign wr_xfer               = av_write && !av_waitrequest;
    assign av_writedata          = (state == WRITE) ? wr_data : '0;
    assign av_read               = (state == READ_REQ);
    assign av_beginbursttransfer = first;

`ifdef AV_BURST_MASTER_BYTEENABLE_EN
    assign av_byteenable = (state == WRITE) ? wr_be : ((state == READ_REQ) ? '1 : '0);
`else
    logic unused_be;
    assign unused_be     = ^wr_be;
    assign av_byteenable = '1;
`endif

    assign rd_valid = (fifo_cnt != '0);
    assign rd_data  = rd_valid ? fifo_mem[rd_ptr][DATA_W-1:0] : '0;
    assign rd_last  = rd_valid && fifo_mem[rd_ptr][DATA_W];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = cmd_write ? WRITE : READ_REQ;
            WRITE:     if (wr_xfer && beat_last) state_nxt = IDLE;
            // A single-beat response may arrive together with the request acceptance.
            READ_REQ:  if (!av_waitrequest) state_nxt = (push && beat_last) ? IDLE : READ_DATA;
            READ_DATA: if (push && beat_last) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            first          <= 1'b0;
            av_address     <= '0;
            av_burstcount  <= '0;
            beat_cnt       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            err_unexpected <= 1'b0;
        end else begin
            state <= state_nxt;
            first <= accept;
            if (accept) begin
                av_address    <= cmd_addr;
                av_burstcount <= bc;
                beat_cnt      <= '0;
            end else if (wr_xfer || push) begin
                beat_cnt <= beat_cnt + BC_W'(1);
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (av_readdatavalid && !in_read) err_unexpected <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {beat_last, av_readdata};
    end
endmodule

// File: tb/tb_av_burst_master.sv
// tb/tb_av_burst_master.sv - directed self-checking bench for av_burst_master
module tb_av_burst_master;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int MAX_BURST = 16;
    localparam int DEPTH = 16;
    localparam int BC_W = 5;

    logic clk, rst;
    logic cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [BC_W-1:0] cmd_burstcount;
    logic wr_valid, wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W/8-1:0] wr_be;
    logic rd_valid, rd_ready, rd_last, err_unexpected;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] av_address;
    logic av_read, av_write, av_waitrequest, av_readdatavalid, av_beginbursttransfer;
    logic [DATA_W-1:0] av_readdata, av_writedata;
    logic [DATA_W/8-1:0] av_byteenable;
    logic [BC_W-1:0] av_burstcount;

    av_burst_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .RD_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_burstcount(cmd_burstcount), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_be(wr_be), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .err_unexpected(err_unexpected), .av_address(av_address), .av_read(av_read),
        .av_write(av_write), .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
        .av_readdatavalid(av_readdatavalid), .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_burstcount(av_burstcount), .av_beginbursttransfer(av_beginbursttransfer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    logic [31:0] wq[$];
    logic [31:0] rq[$];
    bit lq[$];
    int begin_cnt, wready_bad, hold_bad, cyc_used, lat_bad, rd_hi_bad;
    logic [BC_W-1:0] obs_bc;
    bit acc_ok;
    logic post_write, post_ready;

    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [BC_W-1:0] bcnt, output bit ok);
        ok = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_burstcount = bcnt;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic drive_write(input logic [BC_W-1:0] cmd_bc, input int nbeats, input logic [15:0] wait_mask,
                               input logic [15:0] gap_mask, input logic [31:0] addr);
        int idx; bit ok;
        wq.delete(); begin_cnt = 0; wready_bad = 0; hold_bad = 0; cyc_used = 0; idx = 0;
        issue_cmd(1'b1, addr, cmd_bc, ok);
        acc_ok = ok;
        for (int c = 0; c < 40 && idx < nbeats; c++) begin
            @(negedge clk);
            av_waitrequest = (c < 16) ? wait_mask[c] : 1'b0;
            wr_valid = (c < 16) ? !gap_mask[c] : 1'b1;
            wr_data = 32'hA0 + 32'(idx);
            wr_be = '1;
            #1;
            if (c == 0) obs_bc = av_burstcount;
            if (av_beginbursttransfer) begin_cnt++;
            if (wr_ready !== !av_waitrequest) wready_bad++;
            if (av_address !== addr || av_burstcount !== obs_bc) hold_bad++;
            if (av_write && !av_waitrequest) begin wq.push_back(av_writedata); idx++; end
            cyc_used++;
        end
        @(negedge clk);
        av_waitrequest = 0; wr_valid = 1; wr_data = 32'hEE;
        #1;
        post_write = av_write;
        post_ready = cmd_ready;
        wr_valid = 0;
    endtask

    task automatic drive_read(input logic [31:0] addr, input logic [BC_W-1:0] cmd_bc, input int nbeats,
                              input int req_wait, input logic [15:0] rdv_mask, input logic [31:0] base,
                              input logic rdy);
        int sent; bit ok; bit prev_push; bit v;
        rq.delete(); lq.delete(); lat_bad = 0; rd_hi_bad = 0; begin_cnt = 0; sent = 0; prev_push = 0;
        issue_cmd(1'b0, addr, cmd_bc, ok);
        acc_ok = ok;
        rd_ready = rdy;
        for (int c = 0; c < req_wait; c++) begin
            @(negedge clk);
            av_waitrequest = 1; av_readdatavalid = 0;
            #1;
            if (!av_read || av_address !== addr || av_byteenable !== '1) rd_hi_bad++;
            if (av_beginbursttransfer) begin_cnt++;
        end
        for (int c = 0; c < 40 && (sent < nbeats || prev_push); c++) begin
            @(negedge clk);
            av_waitrequest = 0;
            v = (c < 16) ? rdv_mask[c] : 1'b1;
            v = v && (sent < nbeats);
            av_readdatavalid = v;
            av_readdata = base + 32'(sent);
            #1;
            if (c == 0 && (!av_read || av_address !== addr)) rd_hi_bad++;
            if (c > 0 && av_read) rd_hi_bad++;
            if (av_beginbursttransfer) begin_cnt++;
            if (rdy) begin
                if (rd_valid !== prev_push) lat_bad++;
                if (rd_valid) begin rq.push_back(rd_data); lq.push_back(rd_last); end
            end
            prev_push = v;
            if (v) sent++;
        end
        @(negedge clk);
        av_readdatavalid = 0; cmd_write = 0; cmd_burstcount = 1;
        #1;
        post_ready = cmd_ready;
    endtask

    task automatic test_reset();
        rst = 1; cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h55; cmd_burstcount = 4;
        wr_valid = 0; wr_data = 0; wr_be = 0; rd_ready = 0;
        av_waitrequest = 0; av_readdata = 0; av_readdatavalid = 0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); else passed++;
        total++; if ({av_read, av_write, av_beginbursttransfer, wr_ready, rd_valid, rd_last, err_unexpected} !== 7'b0)
            $display("FAIL reset_flags: got %b want 0", {av_read, av_write, av_beginbursttransfer, wr_ready, rd_valid, rd_last, err_unexpected});
        else passed++;
        total++; if (av_address !== 0 || av_burstcount !== 0 || rd_data !== 0 || av_writedata !== 0)
            $display("FAIL reset_regs: got addr %h bc %0d rd %h wd %h want 0", av_address, av_burstcount, rd_data, av_writedata);
        else passed++;
        rst = 0; cmd_valid = 0;
    endtask

    task automatic test_write_burst();
        drive_write(5'd4, 4, 16'h0, 16'h0, 32'h100);
        total++; if (acc_ok !== 1'b1) $display("FAIL wr_accept: got %b want 1", acc_ok); else passed++;
        total++; if (wq.size() != 4) $display("FAIL wr_beats: got %0d want 4", wq.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= wq.size() || wq[i] !== 32'hA0 + 32'(i)) $display("FAIL wr_data%0d: got %h want %h", i, (i < wq.size()) ? wq[i] : 32'hx, 32'hA0 + 32'(i));
            else passed++;
        end
        total++; if (obs_bc !== 5'd4 || hold_bad != 0) $display("FAIL wr_bc_hold: got bc %0d bad %0d want 4/0", obs_bc, hold_bad); else passed++;
        total++; if (begin_cnt != 1) $display("FAIL wr_begin: got %0d want 1", begin_cnt); else passed++;
        total++; if (cyc_used != 4) $display("FAIL wr_cycles: got %0d want 4", cyc_used); else passed++;
        total++; if (post_write !== 1'b0 || post_ready !== 1'b1) $display("FAIL wr_idle: got write %b ready %b want 0/1", post_write, post_ready); else passed++;
    endtask

    task automatic test_write_stall();
        drive_write(5'd4, 4, 16'h0006, 16'h0010, 32'h180);
        total++; if (wq.size() != 4) $display("FAIL ws_beats: got %0d want 4", wq.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= wq.size() || wq[i] !== 32'hA0 + 32'(i)) $display("FAIL ws_data%0d: got %h want %h", i, (i < wq.size()) ? wq[i] : 32'hx, 32'hA0 + 32'(i));
            else passed++;
        end
        total++; if (wready_bad != 0) $display("FAIL ws_wr_ready: got %0d bad cycles want 0", wready_bad); else passed++;
        total++; if (cyc_used != 7) $display("FAIL ws_cycles: got %0d want 7", cyc_used); else passed++;
        total++; if (post_write !== 1'b0) $display("FAIL ws_idle: got %b want 0", post_write); else passed++;
    endtask

    task automatic test_read_burst();
        drive_read(32'h200, 5'd8, 8, 1, 16'h076D, 32'hB0, 1'b1);
        total++; if (acc_ok !== 1'b1) $display("FAIL rd_accept: got %b want 1", acc_ok); else passed++;
        total++; if (begin_cnt != 1 || rd_hi_bad != 0) $display("FAIL rd_request: got begin %0d bad %0d want 1/0", begin_cnt, rd_hi_bad); else passed++;
        total++; if (lat_bad != 0) $display("FAIL rd_latency: got %0d bad cycles want 0", lat_bad); else passed++;
        total++; if (rq.size() != 8) $display("FAIL rd_beats: got %0d want 8", rq.size()); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= rq.size() || rq[i] !== 32'hB0 + 32'(i) || lq[i] !== (i == 7))
                $display("FAIL rd_beat%0d: got %h/%b want %h/%b", i, (i < rq.size()) ? rq[i] : 32'hx, (i < lq.size()) ? lq[i] : 1'b0, 32'hB0 + 32'(i), i == 7);
            else passed++;
        end
        total++; if (post_ready !== 1'b1) $display("FAIL rd_idle: got %b want 1", post_ready); else passed++;
    endtask

    task automatic test_backpressure();
        int bad; logic [31:0] exp_d; bit exp_l;
        drive_read(32'h400, 5'd8, 8, 0, 16'h00FF, 32'hC0, 1'b0);
        total++; if (acc_ok !== 1'b1) $display("FAIL bp_first: got %b want 1", acc_ok); else passed++;
        drive_read(32'h500, 5'd8, 8, 0, 16'h00FF, 32'hD0, 1'b0);
        total++; if (acc_ok !== 1'b1) $display("FAIL bp_second: got %b want 1", acc_ok); else passed++;
        bad = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h600; cmd_burstcount = 1;
        for (int i = 0; i < 3; i++) begin
            #1; if (cmd_ready !== 1'b0 || av_read !== 1'b0) bad++;
            @(negedge clk);
        end
        total++; if (bad != 0) $display("FAIL bp_blocked: got %0d ready cycles want 0", bad); else passed++;
        rd_ready = 1;
        #1;
        total++; if (cmd_ready !== 1'b0 || rd_data !== 32'hC0 || rd_last !== 1'b0)
            $display("FAIL bp_head: got ready %b data %h last %b want 0/c0/0", cmd_ready, rd_data, rd_last);
        else passed++;
        @(negedge clk);
        rd_ready = 0;
        #1;
        total++; if (cmd_ready !== 1'b1) $display("FAIL bp_unblock: got %b want 1", cmd_ready); else passed++;
        @(posedge clk); #1;
        cmd_valid = 0;
        @(negedge clk);
        av_waitrequest = 0; av_readdatavalid = 1; av_readdata = 32'hE0;
        #1;
        total++; if (av_read !== 1'b1 || av_beginbursttransfer !== 1'b1) $display("FAIL bp_third_req: got read %b begin %b want 1/1", av_read, av_beginbursttransfer); else passed++;
        @(negedge clk);
        av_readdatavalid = 0;
        rq.delete(); lq.delete();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rd_ready = 1;
            #1;
            if (!rd_valid) break;
            rq.push_back(rd_data); lq.push_back(rd_last);
        end
        rd_ready = 0;
        total++; if (rq.size() != 16) $display("FAIL bp_drain_count: got %0d want 16", rq.size()); else passed++;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 7) ? 32'hC1 + 32'(i) : ((i < 15) ? 32'hD0 + 32'(i - 7) : 32'hE0);
            exp_l = (i == 6) || (i == 14) || (i == 15);
            if (i >= rq.size() || rq[i] !== exp_d || lq[i] !== exp_l) bad++;
        end
        total++; if (bad != 0) $display("FAIL bp_drain_order: got %0d wrong entries want 0", bad); else passed++;
    endtask

    task automatic test_burstcount_norm();
        drive_write(5'd0, 1, 16'h0, 16'h0, 32'h700);
        total++; if (obs_bc !== 5'd1 || wq.size() != 1 || post_write !== 1'b0)
            $display("FAIL bc_zero: got bc %0d beats %0d post %b want 1/1/0", obs_bc, wq.size(), post_write);
        else passed++;
        drive_write(5'd31, 16, 16'h0, 16'h0, 32'h800);
        total++; if (obs_bc !== 5'd16 || wq.size() != 16 || post_write !== 1'b0)
            $display("FAIL bc_clamp: got bc %0d beats %0d post %b want 16/16/0", obs_bc, wq.size(), post_write);
        else passed++;
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        rd_ready = 0;
        issue_cmd(1'b0, 32'h300, 5'd8, ok);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            av_waitrequest = 0; av_readdatavalid = 1; av_readdata = 32'hF0 + 32'(i);
        end
        @(negedge clk);
        av_readdatavalid = 0; rst = 1;
        @(negedge clk);
        #1;
        total++; if (rd_valid !== 1'b0 || rd_data !== 0 || rd_last !== 1'b0)
            $display("FAIL rst_fifo: got valid %b data %h last %b want 0", rd_valid, rd_data, rd_last);
        else passed++;
        total++; if ({av_read, av_write, av_beginbursttransfer, cmd_ready, err_unexpected} !== 5'b0 || av_address !== 0 || av_burstcount !== 0)
            $display("FAIL rst_outputs: got %b addr %h bc %0d want 0", {av_read, av_write, av_beginbursttransfer, cmd_ready, err_unexpected}, av_address, av_burstcount);
        else passed++;
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            av_readdatavalid = 1; av_readdata = 32'hF3 + 32'(i);
        end
        @(negedge clk);
        av_readdatavalid = 0;
        #1;
        total++; if (err_unexpected !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL rst_late_beats: got err %b valid %b want 1/0", err_unexpected, rd_valid);
        else passed++;
        drive_read(32'h900, 5'd2, 2, 0, 16'h0003, 32'h90, 1'b1);
        total++; if (acc_ok !== 1'b1 || rq.size() != 2) $display("FAIL rst_next_cmd: got acc %b beats %0d want 1/2", acc_ok, rq.size()); else passed++;
        total++; if (rq.size() != 2 || rq[0] !== 32'h90 || rq[1] !== 32'h91 || lq[1] !== 1'b1 || err_unexpected !== 1'b1)
            $display("FAIL rst_next_data: got %0d beats err %b want 90,91 last err 1", rq.size(), err_unexpected);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_write_stall();
        test_read_burst();
        test_backpressure();
        test_burstcount_norm();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion want finish");
        $fatal(1);
    end
endmodule
